// File: rtl/isqrt_shared_arbiter.sv
// Shared pipelined integer square root with round-robin requester arbitration,
// tag tracking and a credit-protected output FIFO.

// Fixed-latency (16-stage) pipelined 32-bit integer square root, one bit per stage.
module isqrt_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int unsigned STAGES = 16;

  logic [STAGES-1:0] vld_q;
  logic [31:0]       rem_q  [STAGES];
  logic [15:0]       root_q [STAGES];

  // Cost of setting bit b on top of the partial root: (root + 2^b)^2 - root^2.
  function automatic logic [33:0] step_delta(input logic [15:0] root, input int unsigned b);
    return (34'(root) << (b + 1)) | (34'd1 << (2 * b));
  endfunction

  function automatic logic [15:0] step_root(input logic [31:0] rem, input logic [15:0] root,
                                            input int unsigned b);
    if (34'(rem) >= step_delta(root, b)) return root | (16'd1 << b);
    return root;
  endfunction

  function automatic logic [31:0] step_rem(input logic [31:0] rem, input logic [15:0] root,
                                           input int unsigned b);
    logic [33:0] delta;
    delta = step_delta(root, b);
    if (34'(rem) >= delta) return 32'(34'(rem) - delta);
    return rem;
  endfunction

  // Pipeline registers: stage k resolves root bit 15-k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        rem_q[k]  <= '0;
        root_q[k] <= '0;
      end
    end else begin
      vld_q     <= {vld_q[STAGES-2:0], x_vld};
      rem_q[0]  <= step_rem(x, 16'd0, STAGES - 1);
      root_q[0] <= step_root(x, 16'd0, STAGES - 1);
      for (int unsigned k = 1; k < STAGES; k++) begin
        rem_q[k]  <= step_rem(rem_q[k-1], root_q[k-1], STAGES - 1 - k);
        root_q[k] <= step_root(rem_q[k-1], root_q[k-1], STAGES - 1 - k);
      end
    end
  end

  assign y_vld = vld_q[STAGES-1];
  assign y     = root_q[STAGES-1];

endmodule

// Register-based FIFO with an occupancy counter driving empty/full.
module flip_flop_fifo_with_counter #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= next_ptr(wr_q);
      end
      if (pop) rd_q <= next_ptr(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// Top: arbitrates requesters onto one isqrt and returns tagged results.
module isqrt_shared_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [32*N_REQ-1:0]      req_x,
  output logic [N_REQ-1:0]         req_rdy,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic [15:0]              res,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     idle
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned RW  = 16 + IDW;

  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic           credit_ok;
  int unsigned    scan_idx;
  logic [31:0]    x_sel;
  logic           issue;
  logic           pop;
  logic           y_vld;
  logic [15:0]    y;
  logic [IDW-1:0] tag_head;
  logic           tag_empty;
  logic           tag_full;
  logic [RW-1:0]  out_head;
  logic           out_empty;
  logic           out_full;

  // Round-robin scan from ptr, gated by available credit.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    req_rdy   = '0;
    credit_ok = (cnt_q < CW'(OUT_DEPTH));
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (credit_ok && !grant_any && req_vld[IDW'(scan_idx)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(scan_idx);
      end
    end
    if (grant_any) req_rdy[grant_id] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    x_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_id == IDW'(k)) x_sel = req_x[k*32 +: 32];
    end
  end

  assign issue = grant_any;
  assign pop   = res_vld & res_rdy;

  // Round-robin pointer and issued-but-not-consumed credit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (issue) ptr_q <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
      case ({issue, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  isqrt_pipe u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .x_vld (issue),
    .x     (x_sel),
    .y_vld (y_vld),
    .y     (y)
  );

  flip_flop_fifo_with_counter #(.W(IDW), .DEPTH(OUT_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (grant_id),
    .pop       (y_vld),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  flip_flop_fifo_with_counter #(.W(RW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (y_vld),
    .push_data ({tag_head, y}),
    .pop       (pop),
    .head      (out_head),
    .empty     (out_empty),
    .full      (out_full)
  );

  assign res_vld = !out_empty;
  assign res     = out_head[15:0];
  assign res_id  = out_head[RW-1:16];
  assign idle    = (cnt_q == '0);

  a_tag_underflow: assert property (@(posedge clk) disable iff (rst) y_vld |-> !tag_empty);
  a_tag_overflow:  assert property (@(posedge clk) disable iff (rst) issue |-> !tag_full);
  a_out_overflow:  assert property (@(posedge clk) disable iff (rst) y_vld |-> !out_full);
  a_grant_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(req_rdy));

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Directed bench for isqrt_shared_arbiter: vector table plus arbitration corner sequences.
module tb_isqrt_shared_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned OUT_DEPTH = 8;
  localparam int unsigned IDW       = 2;
  localparam int unsigned L         = 16;
  localparam int unsigned NVEC      = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_vld;
  logic [32*N_REQ-1:0]   req_x;
  logic [N_REQ-1:0]      req_rdy;
  logic                  res_vld;
  logic                  res_rdy;
  logic [15:0]           res;
  logic [IDW-1:0]        res_id;
  logic                  idle;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]    x;
    logic [IDW-1:0] id;
    logic [15:0]    root;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  isqrt_shared_arbiter #(.N_REQ(N_REQ), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_x   (req_x),
    .req_rdy (req_rdy),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res     (res),
    .res_id  (res_id),
    .idle    (idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (!res_vld && n < 100) begin
      tick();
      n++;
    end
    if (!res_vld) chk(name, 32'(res_vld), 32'd1);
  endtask

  // One isolated request: grant, latency, value, tag, drain back to idle.
  task automatic run_single(input vec_t v);
    int lat;
    req_x[32'(v.id) * 32 +: 32] = v.x;
    req_vld[v.id] = 1'b1;
    #1;
    chk("single_grant", 32'(req_rdy), 32'd1 << v.id);
    tick();
    req_vld[v.id] = 1'b0;
    chk("single_busy", 32'(idle), 32'd0);
    lat = 1;
    while (!res_vld && lat < 100) begin
      tick();
      lat++;
    end
    chk("single_latency", 32'(lat), 32'(L + 1));
    chk("single_res", 32'(res), 32'(v.root));
    chk("single_res_id", 32'(res_id), 32'(v.id));
    tick();
    chk("single_drained", 32'(res_vld), 32'd0);
    chk("single_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] xs [4];
    logic [15:0] roots [4];
    int          n0;
    int          n3;
    int          issues;
    int          gq [8];
    bit          seen;

    vecs[0]  = '{32'd144,        2'd2, 16'd12};
    vecs[1]  = '{32'd0,          2'd0, 16'd0};
    vecs[2]  = '{32'd1,          2'd1, 16'd1};
    vecs[3]  = '{32'd2,          2'd3, 16'd1};
    vecs[4]  = '{32'd3,          2'd0, 16'd1};
    vecs[5]  = '{32'd4,          2'd2, 16'd2};
    vecs[6]  = '{32'd15,         2'd1, 16'd3};
    vecs[7]  = '{32'd16,         2'd3, 16'd4};
    vecs[8]  = '{32'd24,         2'd2, 16'd4};
    vecs[9]  = '{32'd25,         2'd0, 16'd5};
    vecs[10] = '{32'd99,         2'd1, 16'd9};
    vecs[11] = '{32'd65536,      2'd2, 16'd256};
    vecs[12] = '{32'd1000000,    2'd0, 16'd1000};
    vecs[13] = '{32'hFFFE0000,   2'd1, 16'd65534};
    vecs[14] = '{32'hFFFE0001,   2'd2, 16'd65535};
    vecs[15] = '{32'hFFFFFFFF,   2'd3, 16'd65535};

    rst     = 1'b1;
    req_vld = '0;
    req_x   = '0;
    res_rdy = 1'b1;
    repeat (3) tick();
    chk("reset_res_vld", 32'(res_vld), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_req_rdy", 32'(req_rdy), 32'd0);
    rst = 1'b0;
    tick();

    // Table of isolated requests; the last one uses requester 3 so ptr wraps to 0.
    for (int i = 0; i < int'(NVEC); i++) run_single(vecs[i]);

    // All four valid together: granted 0..3 back to back.
    xs[0] = 32'd0; xs[1] = 32'd1; xs[2] = 32'd99; xs[3] = 32'hFFFFFFFF;
    roots[0] = 16'd0; roots[1] = 16'd1; roots[2] = 16'd9; roots[3] = 16'd65535;
    for (int i = 0; i < 4; i++) req_x[i*32 +: 32] = xs[i];
    req_vld = '1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("simul_grant", 32'(req_rdy), 32'd1 << c);
      tick();
      req_vld[c] = 1'b0;
      #1;
    end
    wait_res("simul_wait");
    for (int c = 0; c < 4; c++) begin
      chk("simul_vld", 32'(res_vld), 32'd1);
      chk("simul_res", 32'(res), 32'(roots[c]));
      chk("simul_id", 32'(res_id), 32'(c));
      tick();
    end
    chk("simul_idle", 32'(idle), 32'd1);

    // Requesters 0 and 3 continuously valid: grants alternate.
    req_x[0*32 +: 32] = 32'd49;
    req_x[3*32 +: 32] = 32'd64;
    req_vld = 4'b1001;
    n0 = 0;
    n3 = 0;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk("rr_grant", 32'(req_rdy), (c % 2 == 0) ? 32'd1 : 32'd8);
      if (req_rdy[0]) n0++;
      if (req_rdy[3]) n3++;
      tick();
    end
    req_vld = '0;
    chk("rr_count0", 32'(n0), 32'd4);
    chk("rr_count3", 32'(n3), 32'd4);
    wait_res("rr_wait");
    for (int c = 0; c < 8; c++) begin
      chk("rr_res_id", 32'(res_id), (c % 2 == 0) ? 32'd0 : 32'd3);
      chk("rr_res", 32'(res), (c % 2 == 0) ? 32'd7 : 32'd8);
      tick();
    end
    chk("rr_idle", 32'(idle), 32'd1);

    // Backpressure: exactly OUT_DEPTH issues, then no grants until a pop registers.
    res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) req_x[i*32 +: 32] = 32'((i + 10) * (i + 10));
    req_vld = '1;
    issues = 0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (req_rdy != '0) begin
        for (int j = 0; j < 4; j++) if (req_rdy[j] && issues < 8) gq[issues] = j;
        issues++;
      end
      tick();
    end
    chk("bp_issues", 32'(issues), 32'(OUT_DEPTH));
    for (int i = 0; i < 8; i++) chk("bp_order", 32'(gq[i]), 32'(i % 4));
    chk("bp_stalled", 32'(req_rdy), 32'd0);
    chk("bp_head_vld", 32'(res_vld), 32'd1);
    chk("bp_head_res", 32'(res), 32'd10);
    tick();
    chk("bp_hold_res", 32'(res), 32'd10);
    chk("bp_hold_id", 32'(res_id), 32'd0);
    res_rdy = 1'b1;
    #1;
    chk("bp_no_early_credit", 32'(req_rdy), 32'd0);
    tick();
    chk("bp_resume", 32'(req_rdy), 32'd1);
    req_vld = '0;
    #1;
    for (int c = 1; c < 8; c++) begin
      chk("bp_drain_vld", 32'(res_vld), 32'd1);
      chk("bp_drain_res", 32'(res), 32'(10 + c % 4));
      chk("bp_drain_id", 32'(res_id), 32'(c % 4));
      tick();
    end
    chk("bp_empty", 32'(res_vld), 32'd0);
    chk("bp_idle", 32'(idle), 32'd1);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) req_x[i*32 +: 32] = 32'd400;
    req_vld = 4'b0111;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_grant", 32'(req_rdy), 32'd1 << c);
      tick();
      req_vld[c] = 1'b0;
      #1;
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_async_idle", 32'(idle), 32'd1);
    chk("rst_async_vld", 32'(res_vld), 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < int'(L) + 8; c++) begin
      if (res_vld) seen = 1'b1;
      tick();
    end
    chk("rst_no_stale_res", 32'(seen), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    req_vld = '1;
    #1;
    chk("rst_ptr_zero", 32'(req_rdy), 32'd1);
    req_vld = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
